// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - fetch sequencer with one outstanding request and a 2-entry fetch buffer; optional PC_ALIGN_CHECK_EN
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instruction,
  output logic        out_adel
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        discard, discard_nxt;
  logic [1:0]  count;
  logic [1:0]  occ_after;
  logic [31:0] buf_pc0, buf_pc1, buf_ins0, buf_ins1;
  logic        push, pop;
  logic [31:0] push_pc, push_ins;
`ifdef PC_ALIGN_CHECK_EN
  logic        halt, halt_nxt;
  logic        adel_pend, adel_pend_nxt;
  logic        push_adel, buf_adel0, buf_adel1;
`endif

  assign ireq_addr       = pc;
  assign out_valid       = (count != 2'd0);
  assign out_pc          = buf_pc0;
  assign out_instruction = buf_ins0;
`ifdef PC_ALIGN_CHECK_EN
  assign out_adel        = buf_adel0;
`else
  assign out_adel        = 1'b0;
`endif

  // A redirect flushes the buffer, so it also suppresses consumption.
  assign pop       = out_valid && !stall && !redirect_valid;
  assign occ_after = count - {1'b0, pop};

  // Control registers: FSM state, fetch pointer, drop-next-response flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      discard   <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      halt      <= 1'b0;
      adel_pend <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      discard   <= discard_nxt;
`ifdef PC_ALIGN_CHECK_EN
      halt      <= halt_nxt;
      adel_pend <= adel_pend_nxt;
`endif
    end
  end

  // Next-state, request issue and buffer push selection.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    discard_nxt = discard;
    push        = 1'b0;
    push_pc     = pc;
    push_ins    = iresp_data;
    ireq_valid  = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    halt_nxt      = halt;
    adel_pend_nxt = adel_pend;
    push_adel     = 1'b0;
`endif
    case (state)
      S_REQ: begin
        // Only request when the response is guaranteed a free slot.
        ireq_valid = reset && (occ_after < 2'd2);
`ifdef PC_ALIGN_CHECK_EN
        if (halt) ireq_valid = 1'b0;
`endif
        if (ireq_valid && ireq_ready) begin
          state_nxt   = S_WAIT;
          discard_nxt = redirect_valid;
        end
      end
      S_WAIT: begin
        if (iresp_valid) begin
          state_nxt   = S_REQ;
          discard_nxt = 1'b0;
          if (!discard && !redirect_valid) begin
            push   = 1'b1;
            pc_nxt = pc + 32'd4;
          end
        end else if (redirect_valid) begin
          discard_nxt = 1'b1;
        end
      end
      default: state_nxt = S_REQ;
    endcase
    if (redirect_valid) begin
`ifdef PC_ALIGN_CHECK_EN
      pc_nxt        = redirect_pc;
      halt_nxt      = (redirect_pc[1:0] != 2'b00);
      adel_pend_nxt = (redirect_pc[1:0] != 2'b00);
`else
      pc_nxt = redirect_pc & ~32'h3;
`endif
    end
`ifdef PC_ALIGN_CHECK_EN
    else if (adel_pend && (occ_after < 2'd2)) begin
      // Any response still in flight is being discarded, so this cannot collide with a fetch push.
      push          = 1'b1;
      push_adel     = 1'b1;
      push_ins      = 32'h0000_0000;
      adel_pend_nxt = 1'b0;
    end
`endif
  end

  // Two-entry in-order buffer; entry 0 is the head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= 2'd0;
      buf_pc0   <= 32'h0;
      buf_pc1   <= 32'h0;
      buf_ins0  <= 32'h0;
      buf_ins1  <= 32'h0;
`ifdef PC_ALIGN_CHECK_EN
      buf_adel0 <= 1'b0;
      buf_adel1 <= 1'b0;
`endif
    end else if (redirect_valid) begin
      count <= 2'd0;
    end else if (push && pop) begin
      if (count == 2'd1) begin
        buf_pc0   <= push_pc;
        buf_ins0  <= push_ins;
`ifdef PC_ALIGN_CHECK_EN
        buf_adel0 <= push_adel;
`endif
      end else begin
        buf_pc0   <= buf_pc1;
        buf_ins0  <= buf_ins1;
        buf_pc1   <= push_pc;
        buf_ins1  <= push_ins;
`ifdef PC_ALIGN_CHECK_EN
        buf_adel0 <= buf_adel1;
        buf_adel1 <= push_adel;
`endif
      end
    end else if (push) begin
      if (count == 2'd0) begin
        buf_pc0   <= push_pc;
        buf_ins0  <= push_ins;
`ifdef PC_ALIGN_CHECK_EN
        buf_adel0 <= push_adel;
`endif
      end else begin
        buf_pc1   <= push_pc;
        buf_ins1  <= push_ins;
`ifdef PC_ALIGN_CHECK_EN
        buf_adel1 <= push_adel;
`endif
      end
      count <= count + 2'd1;
    end else if (pop) begin
      buf_pc0   <= buf_pc1;
      buf_ins0  <= buf_ins1;
`ifdef PC_ALIGN_CHECK_EN
      buf_adel0 <= buf_adel1;
`endif
      count     <= count - 2'd1;
    end
  end

endmodule
